// File: rtl/lvds_word_deser_s8_if.sv
// LVDS deserialiser lane bundle: serial samples and controls in,
// assembled words, word strobe and per-channel delay values out.
interface lvds_word_deser_s8_if #(
   parameter int S = 8,
   parameter int D = 3
);
   logic [D-1:0]   datain_p;
   logic [D-1:0]   datain_n;
   logic           rxserdesstrobe;
   logic           bitslip;
   logic           use_phase_detector;
   logic [S*D-1:0] data_out;
   logic           data_valid;
   logic [9*D-1:0] delayVals;

   modport master (
      output datain_p, datain_n, rxserdesstrobe,
      output bitslip, use_phase_detector,
      input  data_out, data_valid, delayVals
   );

   modport slave (
      input  datain_p, datain_n, rxserdesstrobe,
      input  bitslip, use_phase_detector,
      output data_out, data_valid, delayVals
   );
endinterface

// File: rtl/lvds_word_deser_s8.sv
// 1:S LVDS word deserialiser with bitslip alignment and a
// per-channel early/late phase tracker producing signed delays.
module lvds_word_deser_s8 #(
   parameter int S         = 8,
   parameter int D         = 3,
   parameter int PD_WORDS  = 16,
   parameter int PD_THRESH = 4
) (
   input logic                 rxioclk,
   input logic                 reset,
   lvds_word_deser_s8_if.slave rx
);
   localparam int OW = (S > 2) ? $clog2(S) : 1;
   localparam int WW = $clog2(PD_WORDS + 1);
   localparam int CW = 16;
   localparam logic [OW-1:0] OMAX = OW'(S - 1);
   localparam logic [WW-1:0] WLAST = WW'(PD_WORDS - 1);
   localparam logic signed [CW-1:0] ONE = 16'sd1;
   localparam logic signed [CW-1:0] TH_P = CW'(PD_THRESH);
   localparam logic signed [CW-1:0] TH_N = -TH_P;
   localparam logic signed [8:0] DMAX = 9'sd255;
   localparam logic signed [8:0] DMIN = -9'sd255;

   logic [2*S-1:0]        sr     [D];
   logic [2*S-1:0]        sr_nx  [D];
   logic signed [CW-1:0]  cnt    [D];
   logic signed [CW-1:0]  cnt_nx [D];
   logic [S*D-1:0]        dout_q;
   logic                  valid_q;
   logic [OW-1:0]         off;
   logic [OW-1:0]         off_act;
   logic [D-1:0]          prev_p;
   logic [D-1:0]          prev_ns;
   logic [WW-1:0]         win;
   logic                  win_end;
   logic [9*D-1:0]        dly_q;
   logic [9*D-1:0]        dly_nx;
   logic signed [8:0]     cur;

   // Next shift contents, vote accumulation and window-end delay step
   always_comb begin
      win_end = rx.use_phase_detector && rx.rxserdesstrobe
                && (win == WLAST);
      dly_nx  = dly_q;
      cur     = '0;
      for (int d = 0; d < D; d++) begin
         sr_nx[d]  = {sr[d][2*S-2:0], rx.datain_p[d]};
         cnt_nx[d] = cnt[d];
         if (rx.datain_p[d] != prev_p[d])
            cnt_nx[d] = (prev_ns[d] == rx.datain_p[d]) ?
                        cnt[d] + ONE : cnt[d] - ONE;
         cur = $signed(dly_q[d*9 +: 9]);
         if (win_end) begin
            if (cnt_nx[d] >= TH_P && cur != DMAX)
               dly_nx[d*9 +: 9] = cur + 9'sd1;
            else if (cnt_nx[d] <= TH_N && cur != DMIN)
               dly_nx[d*9 +: 9] = cur - 9'sd1;
         end
      end
   end

   // Shift every bit in; capture the aligned word on the strobe edge
   always_ff @(posedge rxioclk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < D; d++) sr[d] <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         for (int d = 0; d < D; d++) sr[d] <= sr_nx[d];
         valid_q <= rx.rxserdesstrobe;
         if (rx.rxserdesstrobe)
            for (int d = 0; d < D; d++)
               dout_q[d*S +: S] <= sr_nx[d][off_act +: S];
      end
   end

   // Slip requests bump the offset; words pick it up at a strobe
   always_ff @(posedge rxioclk or negedge reset) begin
      if (!reset) begin
         off     <= '0;
         off_act <= '0;
      end else begin
         if (rx.bitslip)
            off <= (off == OMAX) ? '0 : off + 1'b1;
         if (rx.rxserdesstrobe)
            off_act <= off;
      end
   end

   // Phase tracker state: history, vote counters, window, delays
   always_ff @(posedge rxioclk or negedge reset) begin
      if (!reset) begin
         prev_p  <= '0;
         prev_ns <= '0;
         win     <= '0;
         dly_q   <= '0;
         for (int d = 0; d < D; d++) cnt[d] <= '0;
      end else begin
         prev_p  <= rx.datain_p;
         prev_ns <= ~rx.datain_n;
         if (!rx.use_phase_detector) begin
            win <= '0;
            for (int d = 0; d < D; d++) cnt[d] <= '0;
         end else begin
            dly_q <= dly_nx;
            if (rx.rxserdesstrobe)
               win <= win_end ? '0 : win + 1'b1;
            for (int d = 0; d < D; d++)
               cnt[d] <= win_end ? '0 : cnt_nx[d];
         end
      end
   end

   assign rx.data_out   = dout_q;
   assign rx.data_valid = valid_q;
   assign rx.delayVals  = dly_q;
endmodule

// File: tb/tb_lvds_word_deser_s8.sv
// Directed bench for lvds_word_deser_s8: reset, alignment, bitslip,
// phase tracking with saturation and asynchronous mid-word reset.
module tb_lvds_word_deser_s8;
   logic rxioclk = 1'b0;
   logic reset   = 1'b0;
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   vcount  = 0;
   logic fr      = 1'b1;
   logic fr_last = 1'b1;
   logic tg      = 1'b0;

   lvds_word_deser_s8_if #(.S(8), .D(3)) bus ();

   lvds_word_deser_s8 #(
      .S(8), .D(3), .PD_WORDS(16), .PD_THRESH(4)
   ) dut (
      .rxioclk (rxioclk),
      .reset   (reset),
      .rx      (bus)
   );

   always #5 rxioclk = ~rxioclk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one 8-bit word of the ADC pattern; slipm marks bitslip cycles
   task automatic send_word(input logic [7:0] slipm);
      logic [7:0] p0, p1, p2;
      p0 = 8'h02;
      p1 = 8'h03;
      p2 = fr ? 8'hFF : 8'h00;
      for (int i = 0; i < 8; i++) begin
         @(negedge rxioclk);
         bus.datain_p = {p2[7-i], p1[7-i], p0[7-i]};
         bus.datain_n = ~bus.datain_p;
         bus.rxserdesstrobe = (i == 7);
         bus.bitslip = slipm[i];
         bus.use_phase_detector = 1'b0;
         @(posedge rxioclk);
         #1;
         vcount += int'(bus.data_valid);
      end
      fr_last = fr;
      fr = ~fr;
   endtask

   task automatic chk_word(input string tag, input bit slipped);
      logic [7:0] e0, e1, e2;
      e0 = slipped ? 8'h01 : 8'h02;
      e1 = slipped ? 8'h81 : 8'h03;
      if (slipped) e2 = fr_last ? 8'h7F : 8'h80;
      else         e2 = fr_last ? 8'hFF : 8'h00;
      check({tag, "_valid"}, 32'(bus.data_valid), 32'd1);
      check({tag, "_ch0"}, 32'(bus.data_out[7:0]), 32'(e0));
      check({tag, "_ch1"}, 32'(bus.data_out[15:8]), 32'(e1));
      check({tag, "_ch2"}, 32'(bus.data_out[23:16]), 32'(e2));
   endtask

   // ch0 toggles every bit; early selects the inverse slave sample
   task automatic pd_words(input int n, input bit early);
      for (int w = 0; w < n; w++) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge rxioclk);
            tg = ~tg;
            bus.datain_p = {1'b0, 1'b0, tg};
            bus.datain_n = {1'b1, 1'b1, early ? ~tg : tg};
            bus.rxserdesstrobe = (i == 7);
            bus.bitslip = 1'b0;
            bus.use_phase_detector = 1'b1;
            @(posedge rxioclk);
            #1;
         end
      end
   endtask

   initial begin
      bus.datain_p = '0;
      bus.datain_n = '0;
      bus.rxserdesstrobe = 1'b0;
      bus.bitslip = 1'b0;
      bus.use_phase_detector = 1'b0;

      for (int i = 0; i < 12; i++) begin
         @(negedge rxioclk);
         bus.datain_p = 3'(i);
         bus.datain_n = ~3'(i);
         bus.rxserdesstrobe = (i % 4 == 3);
         bus.bitslip = i[0];
         bus.use_phase_detector = 1'b1;
      end
      #1;
      check("rst_data", 32'(bus.data_out), 32'd0);
      check("rst_valid", 32'(bus.data_valid), 32'd0);
      check("rst_delay", 32'(bus.delayVals), 32'd0);

      @(negedge rxioclk);
      bus.rxserdesstrobe = 1'b0;
      bus.bitslip = 1'b0;
      bus.use_phase_detector = 1'b0;
      reset = 1'b1;

      vcount = 0;
      for (int w = 0; w < 4; w++) send_word(8'h00);
      check("valid_rate", 32'(vcount), 32'd4);

      send_word(8'h00); chk_word("align0", 1'b0);
      send_word(8'h00); chk_word("align1", 1'b0);
      send_word(8'h00); chk_word("align2", 1'b0);

      send_word(8'h01);
      send_word(8'h00); chk_word("slip0", 1'b1);
      send_word(8'h00); chk_word("slip1", 1'b1);
      send_word(8'h00); chk_word("slip2", 1'b1);

      send_word(8'b0100_1001);
      send_word(8'b0100_1001);
      send_word(8'h01);
      send_word(8'h00); chk_word("wrap0", 1'b0);
      send_word(8'h00); chk_word("wrap1", 1'b0);
      check("pd_off_hold", 32'(bus.delayVals), 32'd0);

      pd_words(16, 1'b0);
      check("late_w1", 32'(bus.delayVals[8:0]), 32'h001);
      pd_words(16, 1'b0);
      check("late_w2", 32'(bus.delayVals[8:0]), 32'h002);
      check("late_ch1", 32'(bus.delayVals[17:9]), 32'h000);
      pd_words(258 * 16, 1'b0);
      check("late_sat", 32'(bus.delayVals[8:0]), 32'h0FF);

      for (int i = 0; i < 3; i++) begin
         @(negedge rxioclk);
         tg = ~tg;
         bus.datain_p = {1'b0, 1'b0, tg};
         bus.rxserdesstrobe = 1'b0;
      end
      @(posedge rxioclk);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_data", 32'(bus.data_out), 32'd0);
      check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
      check("mid_rst_delay", 32'(bus.delayVals), 32'd0);
      @(negedge rxioclk);
      reset = 1'b1;

      pd_words(16, 1'b1);
      check("early_w1", 32'(bus.delayVals[8:0]), 32'h1FF);
      pd_words(259 * 16, 1'b1);
      check("early_sat", 32'(bus.delayVals[8:0]), 32'h101);
      check("early_ch1", 32'(bus.delayVals[17:9]), 32'h000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
